// File: rtl/wb_master_cmd_engine.sv
// Wishbone classic master fed by a small command FIFO.
// One bus cycle per command, ended by ERR, ACK or timeout; one response pulse per command.
module wb_master_cmd_engine #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  output logic              wbm_we_o,
  output logic              wbm_stb_o,
  output logic              wbm_cyc_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(CMD_DEPTH);
  localparam logic [TW-1:0] TCNT_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic          ST_IDLE    = 1'b0;
  localparam logic          ST_WAIT    = 1'b1;
  localparam logic [1:0]    RSP_OK     = 2'b00;
  localparam logic [1:0]    RSP_ERR    = 2'b01;
  localparam logic [1:0]    RSP_TMO    = 2'b10;

  logic [EW-1:0]     mem_q [CMD_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              avail_q;
  logic              state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_status_q, rsp_status_d;

  logic              push, pop, timeout_hit, term;
  logic              head_we;
  logic [ADDR_W-1:0] head_adr;
  logic [DATA_W-1:0] head_dat;

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // avail_q lags the count by one cycle, so a freshly written entry is issued two edges after its push.
  assign pop       = (state_q == ST_IDLE) && avail_q && (count_q != '0);
  assign {head_we, head_adr, head_dat} = mem_q[rd_ptr_q];
  assign timeout_hit = (TIMEOUT_CYC != 0) && (tcnt_q == TCNT_LAST);
  assign term        = (state_q == ST_WAIT) && (wbm_err_i || wbm_ack_i || timeout_hit);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    rsp_valid_d  = 1'b0;
    rsp_write_d  = rsp_write_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    if (pop) begin
      adr_d   = head_adr;
      dat_d   = head_dat;
      we_d    = head_we;
      cyc_d   = 1'b1;
      tcnt_d  = '0;
      state_d = ST_WAIT;
    end else if (state_q == ST_WAIT) begin
      if (term) begin
        state_d     = ST_IDLE;
        cyc_d       = 1'b0;
        we_d        = 1'b0;
        tcnt_d      = '0;
        rsp_valid_d = 1'b1;
        rsp_write_d = we_q;
        rsp_rdata_d = '0;
        if (wbm_err_i) begin
          rsp_status_d = RSP_ERR;
        end else if (wbm_ack_i) begin
          rsp_status_d = RSP_OK;
          if (!we_q) rsp_rdata_d = wbm_dat_i;
        end else begin
          rsp_status_d = RSP_TMO;
        end
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      avail_q      <= 1'b0;
      state_q      <= ST_IDLE;
      tcnt_q       <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      avail_q      <= (count_q != '0);
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_we_o   = we_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign busy       = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_master_cmd_engine.sv
// Bench for wb_master_cmd_engine: directed scenarios plus a randomized run
// checked against a queue-based model of command order and per-address slave behaviour.
module tb_wb_master_cmd_engine;
  localparam int TO = 64;
  typedef struct packed { logic w; logic [3:0] a; logic [7:0] d; } cmd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [3:0] wbm_adr_o;
  logic [7:0] wbm_dat_o, wbm_dat_i;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i, wbm_err_i;
  logic       rsp_valid, rsp_write, busy;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;

  wb_master_cmd_engine #(.ADDR_W(4), .DATA_W(8), .CMD_DEPTH(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave: answers after a fixed number of STB cycles, either from directed knobs or per-address tables.
  logic       use_tab, d_ack_en, d_err_en;
  int         d_wait;
  logic [7:0] d_rdata;
  int         wait_tab [16];
  logic       err_tab [16];
  logic [7:0] rom [16];
  int         slv_cnt = 0;
  int         eff_wait;
  logic       eff_ack, eff_err;
  logic [7:0] eff_rdata;

  always_comb begin
    if (use_tab) begin
      eff_wait  = wait_tab[wbm_adr_o];
      eff_ack   = 1'b1;
      eff_err   = err_tab[wbm_adr_o];
      eff_rdata = rom[wbm_adr_o];
    end else begin
      eff_wait  = d_wait;
      eff_ack   = d_ack_en;
      eff_err   = d_err_en;
      eff_rdata = d_rdata;
    end
  end

  assign wbm_ack_i = wbm_stb_o && eff_ack && (slv_cnt == eff_wait);
  assign wbm_err_i = wbm_stb_o && eff_err && (slv_cnt == eff_wait);
  assign wbm_dat_i = eff_rdata;

  always @(posedge clk) slv_cnt <= (wbm_stb_o && !wbm_ack_i && !wbm_err_i) ? slv_cnt + 1 : 0;

  int   n_chk = 0, n_pass = 0;
  cmd_t src_q[$], pend_q[$], fly_q[$];
  logic rand_valid, prev_cyc, saw_full;
  int   n_rsp, n_iss, low_run, gmin, gmax;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic w, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int stb_cyc, output logic seen);
    stb_cyc = 0;
    seen    = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (wbm_stb_o) stb_cyc++;
      tick();
      if (rsp_valid) seen = 1'b1;
    end
  endtask

  // Expected {status, rdata}: ERR beats ACK, and either only counts if it lands inside the timeout window.
  function automatic logic [9:0] exp_of(input cmd_t c);
    int w; logic e, a; logic [7:0] rd;
    if (use_tab) begin w = wait_tab[c.a]; e = err_tab[c.a]; a = 1'b1; rd = rom[c.a]; end
    else begin w = d_wait; e = d_err_en; a = d_ack_en; rd = d_rdata; end
    if (e && w < TO)      return {2'b01, 8'h00};
    else if (a && w < TO) return {2'b00, c.w ? 8'h00 : rd};
    else                  return {2'b10, 8'h00};
  endfunction

  task automatic step();
    cmd_t c;
    logic offer, pushing;
    logic [9:0] e;
    offer = (src_q.size() != 0) && (!rand_valid || ($urandom_range(0, 3) != 0));
    if (offer) begin
      c = src_q[0];
      cmd_valid = 1'b1; cmd_write = c.w; cmd_addr = c.a; cmd_wdata = c.d;
    end else begin
      cmd_valid = 1'b0;
    end
    pushing = offer && cmd_ready;
    tick();
    cmd_valid = 1'b0;
    if (pushing) pend_q.push_back(src_q.pop_front());
    if (wbm_cyc_o && !prev_cyc) begin
      chk("issue_pending", 32'(pend_q.size() != 0), 32'd1);
      if (pend_q.size() != 0) begin
        c = pend_q.pop_front();
        chk("issue_adr", 32'(wbm_adr_o), 32'(c.a));
        chk("issue_we", 32'(wbm_we_o), 32'(c.w));
        if (c.w) chk("issue_dat", 32'(wbm_dat_o), 32'(c.d));
        if (n_iss != 0) begin
          if (low_run < gmin) gmin = low_run;
          if (low_run > gmax) gmax = low_run;
        end
        n_iss++;
        fly_q.push_back(c);
      end
    end
    if (!wbm_cyc_o) low_run++;
    else low_run = 0;
    if (rsp_valid) begin
      chk("rsp_pending", 32'(fly_q.size() != 0), 32'd1);
      if (fly_q.size() != 0) begin
        c = fly_q.pop_front();
        e = exp_of(c);
        chk("rsp_write", 32'(rsp_write), 32'(c.w));
        chk("rsp_status", 32'(rsp_status), 32'(e[9:8]));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
        n_rsp++;
      end
    end
    if (!cmd_ready) saw_full = 1'b1;
    chk("cmd_ready", 32'(cmd_ready), 32'(pend_q.size() != 4));
    chk("busy", 32'(busy), 32'(pend_q.size() != 0 || fly_q.size() != 0));
    prev_cyc = wbm_cyc_o;
  endtask

  task automatic run_phase(input int budget);
    int i;
    i = 0;
    n_rsp = 0; n_iss = 0; low_run = 0; gmin = 1000; gmax = 0; saw_full = 1'b0;
    prev_cyc = wbm_cyc_o;
    while ((src_q.size() != 0 || pend_q.size() != 0 || fly_q.size() != 0) && i < budget) begin
      step();
      i++;
    end
    chk("phase_drained", 32'(src_q.size() + pend_q.size() + fly_q.size()), 32'd0);
  endtask

  initial begin
    int   sc;
    logic seen, any_rsp, any_cyc;
    cmd_t c;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    use_tab = 1'b0; d_ack_en = 1'b1; d_err_en = 1'b0; d_wait = 0; d_rdata = 8'h00;
    rand_valid = 1'b0; prev_cyc = 1'b0;
    #2;
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 32'd0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_status, rsp_rdata}, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Write 3/A5, zero-wait ACK: CYC from N+2, response at N+3.
    push1(1'b1, 4'h3, 8'hA5);
    chk("t1_busy_N", 32'(busy), 32'd1);
    chk("t1_cyc_N", 32'(wbm_cyc_o), 32'd0);
    tick();
    chk("t1_cyc_N1", 32'(wbm_cyc_o), 32'd0);
    tick();
    chk("t1_bus_N2", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, {17'd0, 3'b111, 4'h3, 8'hA5});
    chk("t1_rsp_N2", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_cyc_N3", 32'(wbm_cyc_o), 32'd0);
    chk("t1_rsp_N3", {rsp_valid, rsp_write, rsp_status, rsp_rdata}, {20'd0, 1'b1, 1'b1, 2'b00, 8'h00});
    tick();
    chk("t1_rsp_N4", {rsp_valid, rsp_status}, 32'd0);
    chk("t1_busy_N4", 32'(busy), 32'd0);

    // Read 7 with three wait states.
    d_wait = 3; d_rdata = 8'h5C;
    push1(1'b0, 4'h7, 8'h00);
    wait_rsp(200, sc, seen);
    chk("t2_seen", 32'(seen), 32'd1);
    chk("t2_stb_cycles", 32'(sc), 32'd4);
    chk("t2_rsp", {rsp_write, rsp_status, rsp_rdata}, {21'd0, 1'b0, 2'b00, 8'h5C});

    // Slave silent: timeout after 64 STB cycles, then a normal command.
    d_ack_en = 1'b0; d_wait = 0;
    push1(1'b0, 4'h1, 8'h00);
    wait_rsp(200, sc, seen);
    chk("t4_seen", 32'(seen), 32'd1);
    chk("t4_stb_cycles", 32'(sc), 32'd64);
    chk("t4_rsp", {rsp_status, rsp_rdata}, {22'd0, 2'b10, 8'h00});
    d_ack_en = 1'b1;
    push1(1'b1, 4'h2, 8'h3C);
    wait_rsp(200, sc, seen);
    chk("t4_next_stb", 32'(sc), 32'd1);
    chk("t4_next_rsp", {rsp_valid, rsp_write, rsp_status}, {28'd0, 1'b1, 1'b1, 2'b00});

    // ACK+ERR together, then ACK exactly on the timeout cycle.
    d_err_en = 1'b1; d_rdata = 8'h77;
    push1(1'b0, 4'h9, 8'h00);
    wait_rsp(200, sc, seen);
    chk("t5_err_rsp", {seen, rsp_status, rsp_rdata}, {21'd0, 1'b1, 2'b01, 8'h00});
    d_err_en = 1'b0; d_wait = TO - 1;
    push1(1'b0, 4'h9, 8'h00);
    wait_rsp(200, sc, seen);
    chk("t5_late_stb", 32'(sc), 32'd64);
    chk("t5_late_rsp", {seen, rsp_status, rsp_rdata}, {21'd0, 1'b1, 2'b00, 8'h77});

    // Five commands against a slow slave: fills the FIFO, order kept, one-cycle gaps.
    d_wait = 10; d_rdata = 8'h4E;
    for (int i = 0; i < 5; i++) begin
      c.w = i[0]; c.a = 4'(i + 4); c.d = 8'(8'h10 * i + 1);
      src_q.push_back(c);
    end
    run_phase(400);
    chk("t3_rsp_count", 32'(n_rsp), 32'd5);
    chk("t3_saw_full", 32'(saw_full), 32'd1);
    chk("t3_gap_min", 32'(gmin), 32'd1);
    chk("t3_gap_max", 32'(gmax), 32'd1);

    // Randomized traffic against per-address slave behaviour.
    for (int i = 0; i < 16; i++) begin
      wait_tab[i] = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 4);
      err_tab[i]  = ($urandom_range(0, 3) == 0);
      rom[i]      = 8'($urandom_range(0, 255));
    end
    use_tab = 1'b1; rand_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c.w = 1'($urandom_range(0, 1)); c.a = 4'($urandom_range(0, 15)); c.d = 8'($urandom_range(0, 255));
      src_q.push_back(c);
    end
    run_phase(8000);
    chk("rand_rsp_count", 32'(n_rsp), 32'd40);
    use_tab = 1'b0; rand_valid = 1'b0;

    // Reset in the middle of a bus cycle with two commands still queued.
    d_wait = 20; d_ack_en = 1'b1;
    push1(1'b1, 4'hA, 8'h11);
    push1(1'b0, 4'hB, 8'h22);
    push1(1'b1, 4'hC, 8'h33);
    chk("t6_inflight", {wbm_cyc_o, wbm_adr_o, busy, cmd_ready}, {25'd0, 1'b1, 4'hA, 1'b1, 1'b1});
    reset = 1'b1;
    #1;
    chk("t6_bus_drop", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    chk("t6_ready_busy", {cmd_ready, busy, rsp_valid}, {29'd0, 3'b100});
    tick(); tick();
    reset = 1'b0;
    any_rsp = 1'b0; any_cyc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) any_rsp = 1'b1;
      if (wbm_cyc_o) any_cyc = 1'b1;
    end
    chk("t6_no_rsp", 32'(any_rsp), 32'd0);
    chk("t6_no_issue", 32'(any_cyc), 32'd0);
    chk("t6_idle", {cmd_ready, busy}, {30'd0, 2'b10});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
